// File: rtl/cacheline_adaptor_pkg.sv
// Shared types and default sizing for the cache-line <-> memory-burst adaptor.
package cacheline_adaptor_pkg;

  localparam int CLA_BEATS   = 4;
  localparam int CLA_BURST_W = 64;
  localparam int CLA_LINE_W  = CLA_BEATS * CLA_BURST_W;
  localparam int CLA_ADDR_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_BURST,
    RD_DONE,
    WR_BURST,
    WR_DONE
  } state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// Cache-line adaptor: splits a cache writeback line into BEATS memory bursts
// and assembles BEATS memory read bursts into one fill line.
// Optional macro CACHELINE_ADAPTOR_ALIGN_EN: when defined, the burst address
// is forced to a line boundary (low 5 address bits cleared).
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int BEATS   = CLA_BEATS,
  parameter int BURST_W = CLA_BURST_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BEATS*BURST_W-1:0] line_i,
  output logic [BEATS*BURST_W-1:0] line_o,
  input  logic [CLA_ADDR_W-1:0]    address_i,
  input  logic                     read_i,
  input  logic                     write_i,
  output logic                     resp_o,
  input  logic [BURST_W-1:0]       burst_i,
  output logic [BURST_W-1:0]       burst_o,
  output logic [CLA_ADDR_W-1:0]    address_o,
  output logic                     read_o,
  output logic                     write_o,
  input  logic                     resp_i
);

  localparam int LINE_BITS = BEATS * BURST_W;
  localparam int KW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(BEATS - 1);

  state_e                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [CLA_ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_BITS-1:0]    wline_q, wline_d;
  logic [LINE_BITS-1:0]    rline_q, rline_d;
  logic [CLA_ADDR_W-1:0]   addr_in;

  // Line-aligned address when alignment is enabled; the raw address otherwise.
`ifdef CACHELINE_ADAPTOR_ALIGN_EN
  assign addr_in = {address_i[CLA_ADDR_W-1:5], 5'b0};
`else
  assign addr_in = address_i;
`endif

  // Next-state logic: request acceptance, beat counting and line assembly.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    case (state_q)
      IDLE: begin
        if (write_i) begin
          addr_d  = addr_in;
          wline_d = line_i;
          k_d     = '0;
          state_d = WR_BURST;
        end else if (read_i) begin
          addr_d  = addr_in;
          k_d     = '0;
          state_d = RD_BURST;
        end
      end
      RD_BURST: begin
        if (resp_i) begin
          for (int b = 0; b < BEATS; b++) begin
            if (k_q == KW'(b)) begin
              rline_d[b*BURST_W +: BURST_W] = burst_i;
            end
          end
          if (k_q == LAST_K) begin
            k_d     = '0;
            state_d = RD_DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      WR_BURST: begin
        if (resp_i) begin
          if (k_q == LAST_K) begin
            k_d     = '0;
            state_d = WR_DONE;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      RD_DONE:  state_d = IDLE;
      WR_DONE:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State, counter and data registers; reset aborts any burst in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  // Outputs decoded from registered state so they are glitch-free and exclusive.
  always_comb begin
    read_o    = (state_q == RD_BURST);
    write_o   = (state_q == WR_BURST);
    resp_o    = (state_q == RD_DONE) || (state_q == WR_DONE);
    line_o    = rline_q;
    address_o = addr_q;
    burst_o   = '0;
    if (state_q == WR_BURST) begin
      for (int b = 0; b < BEATS; b++) begin
        if (k_q == KW'(b)) begin
          burst_o = wline_q[b*BURST_W +: BURST_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed self-checking bench for cacheline_adaptor (default 4 x 64-bit beats).
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int total = 0;
  int bad = 0;
  int resp_count = 0;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  // Count completion pulses mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (resp_o === 1'b1) resp_count++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    line_i = '0; address_i = '0; burst_i = '0;
    #2;
    total++; if (read_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_read_o got=%0b want=0", read_o); end
    total++; if (write_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_write_o got=%0b want=0", write_o); end
    total++; if (resp_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_resp_o got=%0b want=0", resp_o); end
    total++; if (line_o !== 256'h0) begin bad++; $display("[TB] FAIL reset_line_o got=%h want=0", line_o); end
    total++; if (burst_o !== 64'h0) begin bad++; $display("[TB] FAIL reset_burst_o got=%h want=0", burst_o); end
    total++; if (address_o !== 32'h0) begin bad++; $display("[TB] FAIL reset_address_o got=%h want=0", address_o); end
    tick; tick;
    rst = 1'b1;
    tick;
    total++; if (read_o !== 1'b0 || write_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_release_idle got rd=%0b wr=%0b want 0/0", read_o, write_o); end
  endtask

  task automatic test_read;
    logic [63:0] rb [4];
    logic [31:0] exp_addr;
    rb = '{64'hAAAA_0000_0000_0001, 64'hBBBB_0000_0000_0002, 64'hCCCC_0000_0000_0003, 64'hDDDD_0000_0000_0004};
`ifdef CACHELINE_ADAPTOR_ALIGN_EN
    exp_addr = 32'h0000_1220;
`else
    exp_addr = 32'h0000_1234;
`endif
    read_i = 1'b1; address_i = 32'h0000_1234;
    tick;
    total++; if (read_o !== 1'b1 || write_o !== 1'b0) begin bad++; $display("[TB] FAIL read_start got rd=%0b wr=%0b want 1/0", read_o, write_o); end
    total++; if (address_o !== exp_addr) begin bad++; $display("[TB] FAIL read_address got=%h want=%h", address_o, exp_addr); end
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1; burst_i = rb[i];
      tick;
      if (i < 3) begin
        total++; if (resp_o !== 1'b0 || read_o !== 1'b1) begin bad++; $display("[TB] FAIL read_beat%0d got resp=%0b rd=%0b want 0/1", i, resp_o, read_o); end
      end
    end
    resp_i = 1'b0; burst_i = '0;
    total++; if (resp_o !== 1'b1 || read_o !== 1'b0) begin bad++; $display("[TB] FAIL read_done got resp=%0b rd=%0b want 1/0", resp_o, read_o); end
    total++; if (line_o !== {rb[3], rb[2], rb[1], rb[0]}) begin bad++; $display("[TB] FAIL read_line got=%h want=%h", line_o, {rb[3], rb[2], rb[1], rb[0]}); end
    read_i = 1'b0;
    tick;
    total++; if (resp_o !== 1'b0) begin bad++; $display("[TB] FAIL read_resp_one_cycle got=%0b want=0", resp_o); end
    total++; if (line_o !== {rb[3], rb[2], rb[1], rb[0]}) begin bad++; $display("[TB] FAIL read_line_hold got=%h want=%h", line_o, {rb[3], rb[2], rb[1], rb[0]}); end
  endtask

  task automatic test_write;
    logic [63:0] wb [4];
    logic [255:0] prev_line;
    wb = '{64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC, 64'hDDDD_EEEE_FFFF_0000};
    prev_line = {64'hDDDD_0000_0000_0004, 64'hCCCC_0000_0000_0003, 64'hBBBB_0000_0000_0002, 64'hAAAA_0000_0000_0001};
    write_i = 1'b1; address_i = 32'h0000_8040; line_i = {wb[3], wb[2], wb[1], wb[0]};
    tick;
    for (int i = 0; i < 4; i++) begin
      total++; if (write_o !== 1'b1 || read_o !== 1'b0 || burst_o !== wb[i]) begin bad++; $display("[TB] FAIL write_beat%0d got wr=%0b rd=%0b data=%h want 1/0/%h", i, write_o, read_o, burst_o, wb[i]); end
      resp_i = 1'b1;
      tick;
    end
    resp_i = 1'b0;
    total++; if (resp_o !== 1'b1 || write_o !== 1'b0) begin bad++; $display("[TB] FAIL write_done got resp=%0b wr=%0b want 1/0", resp_o, write_o); end
    total++; if (line_o !== prev_line) begin bad++; $display("[TB] FAIL write_keeps_line got=%h want=%h", line_o, prev_line); end
    write_i = 1'b0;
    tick;
    total++; if (resp_o !== 1'b0) begin bad++; $display("[TB] FAIL write_resp_one_cycle got=%0b want=0", resp_o); end
  endtask

  task automatic test_stall;
    logic        pat [7];
    logic [63:0] sb [4];
    int n;
    int start;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    sb  = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 64'h0F0F_0F0F_F0F0_F0F0, 64'h5A5A_A5A5_3C3C_C3C3};
    n = 0;
    start = resp_count;
    read_i = 1'b1; address_i = 32'h0000_2000;
    tick;
    for (int c = 0; c < 7; c++) begin
      resp_i = pat[c];
      if (pat[c]) begin
        burst_i = sb[n];
        n++;
      end else begin
        burst_i = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      tick;
      if (c < 6) begin
        total++; if (resp_o !== 1'b0 || read_o !== 1'b1) begin bad++; $display("[TB] FAIL stall_cycle%0d got resp=%0b rd=%0b want 0/1", c, resp_o, read_o); end
      end
    end
    resp_i = 1'b0; burst_i = '0;
    total++; if (resp_o !== 1'b1) begin bad++; $display("[TB] FAIL stall_done got=%0b want=1", resp_o); end
    total++; if (line_o !== {sb[3], sb[2], sb[1], sb[0]}) begin bad++; $display("[TB] FAIL stall_line got=%h want=%h", line_o, {sb[3], sb[2], sb[1], sb[0]}); end
    read_i = 1'b0;
    tick; tick;
    total++; if (resp_count - start !== 1) begin bad++; $display("[TB] FAIL stall_resp_count got=%0d want=1", resp_count - start); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] xb [4];
    logic [63:0] yb [4];
    xb = '{64'hA0A0_0000_0000_0000, 64'hA1A1_0000_0000_0001, 64'hA2A2_0000_0000_0002, 64'hA3A3_0000_0000_0003};
    yb = '{64'hB0B0_1111_0000_0000, 64'hB1B1_1111_0000_0001, 64'hB2B2_1111_0000_0002, 64'hB3B3_1111_0000_0003};
    read_i = 1'b1; write_i = 1'b1; address_i = 32'h0000_3000; line_i = {xb[3], xb[2], xb[1], xb[0]};
    tick;
    total++; if (write_o !== 1'b1 || read_o !== 1'b0) begin bad++; $display("[TB] FAIL b2b_write_first got wr=%0b rd=%0b want 1/0", write_o, read_o); end
    for (int i = 0; i < 4; i++) begin
      total++; if (burst_o !== xb[i]) begin bad++; $display("[TB] FAIL b2b_wbeat%0d got=%h want=%h", i, burst_o, xb[i]); end
      resp_i = 1'b1;
      tick;
    end
    resp_i = 1'b0;
    total++; if (resp_o !== 1'b1 || write_o !== 1'b0) begin bad++; $display("[TB] FAIL b2b_write_done got resp=%0b wr=%0b want 1/0", resp_o, write_o); end
    write_i = 1'b0;
    tick;
    total++; if (read_o !== 1'b0 || resp_o !== 1'b0) begin bad++; $display("[TB] FAIL b2b_idle got rd=%0b resp=%0b want 0/0", read_o, resp_o); end
    tick;
    total++; if (read_o !== 1'b1 || write_o !== 1'b0) begin bad++; $display("[TB] FAIL b2b_read_start got rd=%0b wr=%0b want 1/0", read_o, write_o); end
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1; burst_i = yb[i];
      tick;
    end
    resp_i = 1'b0; burst_i = '0;
    total++; if (resp_o !== 1'b1 || line_o !== {yb[3], yb[2], yb[1], yb[0]}) begin bad++; $display("[TB] FAIL b2b_read_done got resp=%0b line=%h want 1/%h", resp_o, line_o, {yb[3], yb[2], yb[1], yb[0]}); end
    read_i = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_burst;
    logic [63:0] zb [4];
    int start;
    zb = '{64'hC0DE_0000_0000_0010, 64'hC0DE_0000_0000_0020, 64'hC0DE_0000_0000_0030, 64'hC0DE_0000_0000_0040};
    start = resp_count;
    read_i = 1'b1; address_i = 32'h0000_4000;
    tick;
    for (int i = 0; i < 2; i++) begin
      resp_i = 1'b1; burst_i = 64'h7777_0000_0000_0000 + 64'(i);
      tick;
    end
    resp_i = 1'b0;
    rst = 1'b0;
    #1;
    total++; if (read_o !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_read_o got=%0b want=0", read_o); end
    total++; if (line_o !== 256'h0 || address_o !== 32'h0 || burst_o !== 64'h0 || resp_o !== 1'b0 || write_o !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_outputs got line=%h addr=%h burst=%h resp=%0b wr=%0b want all 0", line_o, address_o, burst_o, resp_o, write_o); end
    read_i = 1'b0;
    tick; tick;
    rst = 1'b1;
    tick; tick;
    total++; if (resp_count !== start) begin bad++; $display("[TB] FAIL rstmid_no_resp got=%0d want=%0d", resp_count, start); end
    read_i = 1'b1; address_i = 32'h0000_4000;
    tick;
    for (int i = 0; i < 4; i++) begin
      resp_i = 1'b1; burst_i = zb[i];
      tick;
    end
    resp_i = 1'b0; burst_i = '0;
    total++; if (resp_o !== 1'b1 || line_o !== {zb[3], zb[2], zb[1], zb[0]}) begin bad++; $display("[TB] FAIL rstmid_recover got resp=%0b line=%h want 1/%h", resp_o, line_o, {zb[3], zb[2], zb[1], zb[0]}); end
    read_i = 1'b0;
    tick;
  endtask

  task automatic test_stray_resp;
    logic [255:0] held;
    int start;
    held = {64'hC0DE_0000_0000_0040, 64'hC0DE_0000_0000_0030, 64'hC0DE_0000_0000_0020, 64'hC0DE_0000_0000_0010};
    start = resp_count;
    resp_i = 1'b1; burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 0; i < 3; i++) begin
      tick;
      total++; if (read_o !== 1'b0 || write_o !== 1'b0 || resp_o !== 1'b0) begin bad++; $display("[TB] FAIL stray_cycle%0d got rd=%0b wr=%0b resp=%0b want 0/0/0", i, read_o, write_o, resp_o); end
    end
    resp_i = 1'b0; burst_i = '0;
    tick;
    total++; if (line_o !== held) begin bad++; $display("[TB] FAIL stray_line got=%h want=%h", line_o, held); end
    total++; if (resp_count !== start) begin bad++; $display("[TB] FAIL stray_resp_count got=%0d want=%0d", resp_count, start); end
  endtask

  initial begin
    test_reset;
    test_read;
    test_write;
    test_stall;
    test_back_to_back;
    test_reset_mid_burst;
    test_stray_resp;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameter BEATS, default 4, sets the number of memory-side beats per cache line.
REQ-002 Parameter BURST_W, default 64, sets the bit width of one beat; the line width SHALL equal BEATS*BURST_W (256 by default).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 line_i  in  256  cache line to write back (cache pmem_wdata).
REQ-006 line_o  out  256  assembled fill line (to cache pmem_rdata).
REQ-007 address_i  in  32  line address from cache (pmem_address).
REQ-008 read_i / write_i  in  1 each  cache fill / writeback request, held high until resp_o.
REQ-009 resp_o  out  1  one-cycle completion pulse (to cache pmem_resp).
REQ-010 burst_i  in  64  read beat from memory; burst_o  out  64  write beat to memory.
REQ-011 address_o  out  32  burst address; read_o / write_o  out  1 each  memory burst requests.
REQ-012 resp_i  in  1  memory beat strobe; each high cycle transfers exactly one beat.

Function
REQ-013 FSM states: IDLE, RD_BURST, RD_DONE, WR_BURST, WR_DONE.
REQ-014 IDLE: write_i high -> latch address_i and line_i, go WR_BURST; else read_i high -> latch address_i, go RD_BURST; write has priority when both are high.
REQ-015 RD_BURST: read_o high, address_o equals the latched address; on each resp_i, store burst_i into line_o[64k+63:64k], k = beat counter, then increment k.
REQ-016 WR_BURST: write_o high, burst_o = latched line[64k+63:64k]; on each resp_i, increment k.
REQ-017 Beat order is k=0 first (lowest 64 bits) up to k=BEATS-1; the counter is clog2(BEATS) bits and resets to 0 on every new request.
REQ-018 resp_i low in a burst state stalls: k, outputs, and latched data hold.
REQ-019 The beat with k=BEATS-1 and resp_i high moves the FSM to RD_DONE/WR_DONE; read_o/write_o are low in the DONE states.
REQ-020 DONE states: resp_o=1 for exactly one cycle, line_o stable and valid, then go to IDLE.
REQ-021 Read latency: resp_o rises in the cycle after the final resp_i beat; min total 1 (accept) + BEATS + 1 cycles.
REQ-022 resp_i in IDLE or DONE states is ignored; it changes no state.
REQ-023 Deassertion of read_i/write_i mid-burst is ignored; the burst completes and resp_o still pulses.
REQ-024 line_o holds its last assembled value until the next read burst overwrites beats.
REQ-025 read_o and write_o are never high in the same cycle.

Reset
REQ-026 When rst is low, the block SHALL asynchronously enter IDLE, with k=0, read_o=0, write_o=0, resp_o=0, line_o=0, burst_o=0, and address_o=0.
REQ-027 A reset asserted mid-burst SHALL abort the burst immediately; no resp_o follows.

Configuration
REQ-028 Macro CACHELINE_ADAPTOR_ALIGN_EN: when defined, address_o[4:0] is forced to 0 (line-aligned); when undefined, address_o equals the latched address_i unchanged.

Structure
REQ-029 Package cacheline_adaptor_pkg SHALL hold the state enum, the BEATS/BURST_W defaults, and the LINE_W constant.
REQ-030 No sub-module is required; the FSM, beat counter, and line assembly register live in one module.

Verification
REQ-031 Read: read_i=1, address_i=0x0000_1234, resp_i on 4 consecutive cycles with burst_i=A,B,C,D -> address_o=0x0000_1220 (with ALIGN_EN), line_o={D,C,B,A}, one resp_o pulse one cycle after D.
REQ-032 Write: write_i=1, line_i={W3,W2,W1,W0} -> burst_o=W0,W1,W2,W3 on successive resp_i, then resp_o=1 for 1 cycle with write_o=0.
REQ-033 Stall: read burst with resp_i pattern 1,0,0,1,1,0,1 -> line assembled correctly; resp_o exactly once, after the 4th beat.
REQ-034 Simultaneous read_i=1 and write_i=1 in IDLE -> write burst first; after resp_o, a held read_i starts a read burst.
REQ-035 Reset pulse low after 2 read beats -> read_o=0 in the same cycle, all outputs 0, no resp_o; a new read then completes normally.
REQ-036 Stray resp_i=1 in IDLE -> no state change and no resp_o.
